// File: rtl/calc_pkg.sv
// Shared calculator types: BCD digit type, converter FSM states, error code.
package calc_pkg;

   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned DIGIT_W    = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } bcd_state_e;

   // Shown on every digit when the upstream result is invalid.
   localparam bcd_digit_t BCD_ERR_CODE = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the ALU result path and the BCD converter.
interface bin_to_bcd_seq_if #(
   parameter int unsigned IN_W = 9
);
   import calc_pkg::*;

   logic            start_in;
   logic [IN_W-1:0] value_in;
   logic            err_in;
   logic            busy_out;
   logic            done_out;
   bcd_digit_t      dig0_out;
   bcd_digit_t      dig1_out;
   bcd_digit_t      dig2_out;
   logic            sign_out;
   logic            err_out;
   logic [2:0]      blank_out;

   modport master (
      output start_in, value_in, err_in,
      input  busy_out, done_out, dig0_out, dig1_out, dig2_out,
             sign_out, err_out, blank_out
   );

   modport slave (
      input  start_in, value_in, err_in,
      output busy_out, done_out, dig0_out, dig1_out, dig2_out,
             sign_out, err_out, blank_out
   );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: digits of 5 or more get +3 before the shift.
module bcd_add3
   import calc_pkg::*;
(
   input  bcd_digit_t d_i,
   output bcd_digit_t d_o
);

   assign d_o = (d_i >= 4'd5) ? bcd_digit_t'(d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential signed binary to 3-digit BCD converter (shift-add-3).
// Optional leading-zero blank mask enabled by defining BCD_LZ_BLANK_EN.
module bin_to_bcd_seq
   import calc_pkg::*;
#(
   parameter int unsigned IN_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   bin_to_bcd_seq_if.slave  bus
);

   localparam int unsigned BCD_W = DIGIT_W * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_W + 1);

   bcd_state_e              state_q, state_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [IN_W-1:0]         mag_q, mag_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sign_lat_q, sign_lat_d;
   logic                    err_lat_q, err_lat_d;
   bcd_digit_t [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                    sign_q, sign_d;
   logic                    errf_q, errf_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W+IN_W-1:0]   shifted;
   logic [BCD_W-1:0]        bcd_fin;
   logic                    last_c;

   // One adjust cell per BCD digit of the scratch register.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (bcd_q[DIGIT_W*g +: DIGIT_W]),
         .d_o (bcd_adj[DIGIT_W*g +: DIGIT_W])
      );
   end

   assign shifted = {bcd_adj, mag_q} << 1;
   assign bcd_fin = shifted[BCD_W+IN_W-1 -: BCD_W];
   assign last_c  = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bcd_q      <= '0;
         mag_q      <= '0;
         cnt_q      <= '0;
         sign_lat_q <= 1'b0;
         err_lat_q  <= 1'b0;
         dig_q      <= '0;
         sign_q     <= 1'b0;
         errf_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcd_q      <= bcd_d;
         mag_q      <= mag_d;
         cnt_q      <= cnt_d;
         sign_lat_q <= sign_lat_d;
         err_lat_q  <= err_lat_d;
         dig_q      <= dig_d;
         sign_q     <= sign_d;
         errf_q     <= errf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state: latch request in IDLE, iterate in SHIFT, publish on the last step.
   always_comb begin
      state_d    = state_q;
      bcd_d      = bcd_q;
      mag_d      = mag_q;
      cnt_d      = cnt_q;
      sign_lat_d = sign_lat_q;
      err_lat_d  = err_lat_q;
      dig_d      = dig_q;
      sign_d     = sign_q;
      errf_d     = errf_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_in) begin
               sign_lat_d = bus.value_in[IN_W-1];
               // Most-negative input wraps to its own bit pattern, which is the correct magnitude.
               mag_d      = bus.value_in[IN_W-1] ? IN_W'(~bus.value_in + IN_W'(1)) : bus.value_in;
               err_lat_d  = bus.err_in;
               bcd_d      = '0;
               cnt_d      = CNT_W'(IN_W);
               busy_d     = 1'b1;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d = bcd_fin;
            mag_d = shifted[IN_W-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            if (last_c) begin
               dig_d   = err_lat_q ? {NUM_DIGITS{BCD_ERR_CODE}} : bcd_fin;
               sign_d  = sign_lat_q & ~err_lat_q;
               errf_d  = err_lat_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef BCD_LZ_BLANK_EN
   logic [2:0] blank_q, blank_d;

   // Leading-zero mask computed from the digits being published.
   always_comb begin
      blank_d = blank_q;
      if (last_c) begin
         blank_d = 3'b000;
         if (!err_lat_q) begin
            blank_d[2] = (bcd_fin[DIGIT_W*2 +: DIGIT_W] == 4'd0);
            blank_d[1] = (bcd_fin[DIGIT_W*2 +: DIGIT_W] == 4'd0) &&
                         (bcd_fin[DIGIT_W*1 +: DIGIT_W] == 4'd0);
         end
      end
   end

   // Blank mask register, updated with the digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank_q <= 3'b000;
      else        blank_q <= blank_d;
   end

   assign bus.blank_out = blank_q;
`else
   assign bus.blank_out = 3'b000;
`endif

   assign bus.busy_out = busy_q;
   assign bus.done_out = done_q;
   assign bus.dig0_out = dig_q[0];
   assign bus.dig1_out = dig_q[1];
   assign bus.dig2_out = dig_q[2];
   assign bus.sign_out = sign_q;
   assign bus.err_out  = errf_q;

endmodule
